// File: rtl/even_seq_ctrl.sv
// even_seq_ctrl: bounded, back-pressurable sequencer for the even-number
// generator. A start command captures first/last/limit, then an internal
// mod-2^WIDTH counter steps by +2, presenting each term over valid/ready
// until the last term or the term limit is reached, or an abort arrives.
module even_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_first,
    input  logic [WIDTH-1:0] cfg_last,
    input  logic [CNTW-1:0]  cfg_count,
    output logic [WIDTH-1:0] out_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  term_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] last_q;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  idx;
    logic             aborted_q;

    logic             accept;
    logic             handshake;
    logic             final_term;

    // A start is only meaningful while idle; anything else is dropped.
    assign accept     = (state == IDLE) && start;
    assign handshake  = (state == RUN) && out_ready;

    // The presented term is the last one if it matches the programmed end
    // value or if it exhausts a non-zero term limit.
    assign final_term = (cur == last_q) ||
                        ((count_q != '0) && (idx == count_q - CNTW'(1)));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode; abort wins over a same-cycle final handshake.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (abort)                         state_next = IDLE;
                else if (handshake && final_term)  state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Term counter, term index and abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            idx       <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= (state == RUN) && abort;
            if (accept) begin
                cur <= {cfg_first[WIDTH-1:1], 1'b0};
                idx <= '0;
            end else if (handshake && !abort && !final_term) begin
                cur <= cur + WIDTH'(2);
                idx <= idx + CNTW'(1);
            end
        end
    end

    // Captured end value and term limit, frozen for the whole run.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are always written by the start that
        // launches a run before anything reads them.
        if (accept) begin
            last_q  <= {cfg_last[WIDTH-1:1], 1'b0};
            count_q <= cfg_count;
        end
    end

    assign out_value = cur;
    assign out_valid = (state == RUN);
    assign term_idx  = idx;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_even_seq_ctrl.sv
// tb_even_seq_ctrl: directed and randomized runs of even_seq_ctrl checked
// against a term list computed from first/last/limit with plain arithmetic.
module tb_even_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNTW  = 8;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] cfg_first;
    logic [WIDTH-1:0] cfg_last;
    logic [CNTW-1:0]  cfg_count;
    logic [WIDTH-1:0] out_value;
    logic             out_valid;
    logic             out_ready;
    logic [CNTW-1:0]  term_idx;
    logic             busy;
    logic             done;
    logic             aborted;

    int checks   = 0;
    int failures = 0;

    even_seq_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .cfg_count (cfg_count),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .term_idx  (term_idx),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cfg();
        cfg_first = WIDTH'($urandom);
        cfg_last  = WIDTH'($urandom);
        cfg_count = CNTW'($urandom);
    endtask

    // Expected term list: start at the even-rounded first value, add 2
    // modulo 2^WIDTH, stop at the even-rounded last value or after c terms.
    task automatic build_terms(input int f, input int l, input int c, output int q[$]);
        int v;
        int lim;
        q   = {};
        v   = (f % MODV) & ~1;
        lim = (l % MODV) & ~1;
        while (1) begin
            q.push_back(v);
            if (v == lim || (c != 0 && q.size() == c)) break;
            v = (v + 2) % MODV;
        end
    endtask

    // One full run. mode 0: ready always high; 1: random ready;
    // 2: ready pattern 1,0,0,1 repeating. Random starts are injected while
    // busy and cfg is scrambled after capture; neither may affect the run.
    task automatic run_seq(input int f, input int l, input int c, input int mode);
        int  terms[$];
        int  k;
        int  cyc;
        logic rdy;
        build_terms(f, l, c, terms);
        cfg_first = WIDTH'(f);
        cfg_last  = WIDTH'(l);
        cfg_count = CNTW'(c);
        start     = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        scramble_cfg();
        k   = 0;
        cyc = 0;
        while (k < terms.size() && cyc < 200) begin
            check("run_valid", out_valid, 1);
            check("run_value", out_value, terms[k]);
            check("run_idx",   term_idx,  k);
            check("run_busy",  busy,      1);
            check("run_done",  done,      0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                default: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            out_ready = rdy;
            start     = ($urandom % 4) == 0;
            scramble_cfg();
            step();
            cyc++;
            if (rdy) k++;
        end
        if (k < terms.size()) begin
            check("run_timeout", k, terms.size());
            return;
        end
        start     = 1'($urandom);
        out_ready = 1'($urandom);
        check("done_pulse", done,      1);
        check("done_valid", out_valid, 0);
        check("done_busy",  busy,      1);
        check("done_abort", aborted,   0);
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        check("idle_done",  done,      0);
        check("idle_busy",  busy,      0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        cfg_first = '0;
        cfg_last  = '0;
        cfg_count = '0;
        step();
        step();
        check("rst_value", out_value, 0);
        check("rst_valid", out_valid, 0);
        check("rst_idx",   term_idx,  0);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        check("rst_abort", aborted,   0);
        rst = 1'b0;
        step();

        // Directed runs.
        run_seq(0,  8,  0, 0);
        run_seq(5,  15, 3, 0);
        run_seq(12, 2,  0, 0);
        run_seq(6,  6,  0, 0);
        run_seq(0,  6,  0, 2);

        // Abort while presenting 4 with a simultaneous handshake.
        cfg_first = 4'd0;
        cfg_last  = 4'd14;
        cfg_count = '0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) step();
        check("ab_pre_value", out_value, 4);
        abort = 1'b1;
        step();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("ab_pulse", aborted,   1);
        check("ab_valid", out_valid, 0);
        check("ab_busy",  busy,      0);
        check("ab_done",  done,      0);
        step();
        check("ab_pulse_end", aborted, 0);
        check("ab_done_end",  done,    0);
        run_seq(10, 12, 0, 1);

        // Reset in the middle of a run.
        cfg_first = 4'd2;
        cfg_last  = 4'd14;
        cfg_count = '0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("mid_value", out_value, 8);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("mr_value", out_value, 0);
        check("mr_valid", out_valid, 0);
        check("mr_idx",   term_idx,  0);
        check("mr_busy",  busy,      0);
        check("mr_done",  done,      0);
        check("mr_abort", aborted,   0);
        step();
        check("mr_done2",  done,    0);
        check("mr_abort2", aborted, 0);

        // Randomized runs.
        for (int n = 0; n < 40; n++)
            run_seq($urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1),
                    $urandom_range(0, 10), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
